id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand preparation for the 32-bit MIPS-style datapath; drives A, B and the 4-bit OPCODE of the ALU directly.
- Captures decoded fields and register-file data on each clock edge.
- Resolves EX/MEM and MEM/WB forwarding, selects the immediate or shift-amount operand, and decodes ALU control.
- Passes memory and writeback controls downstream.

---
 rtl/id_ex_operand_stage.sv | 217 +++++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand preparation.
// Captures the decoded instruction fields and register-file data, then
// resolves EX/MEM and MEM/WB forwarding. It selects the ALU operands
// (register, immediate or shift amount) and decodes the 4-bit ALU opcode.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   i_stall, i_flush      hold state / load a bubble (flush wins)
//   i_rs_data..i_mem_to_reg  decoded fields and controls from ID
//   i_exmem_*, i_memwb_*  forwarding sources (not registered)
//   o_alu_a, o_alu_b, o_alu_opcode  ALU operands and opcode
//   o_store_data          forwarded rt value for stores
//   o_write_reg, o_rt_ex  destination register and registered rt
//   o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg  downstream controls
module id_ex_operand_stage #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned OP_BITS   = 4,
  parameter int unsigned REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [BUS_WIDTH-1:0] i_rs_data,
  input  logic [BUS_WIDTH-1:0] i_rt_data,
  input  logic [BUS_WIDTH-1:0] i_imm,
  input  logic [4:0]           i_shamt,
  input  logic [5:0]           i_funct,
  input  logic [5:0]           i_opcode,
  input  logic [REG_ADDR-1:0]  i_rs,
  input  logic [REG_ADDR-1:0]  i_rt,
  input  logic [REG_ADDR-1:0]  i_rd,
  input  logic [1:0]           i_alu_op,
  input  logic                 i_alu_src,
  input  logic                 i_reg_dst,
  input  logic                 i_reg_write,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_mem_to_reg,
  input  logic                 i_exmem_reg_write,
  input  logic [REG_ADDR-1:0]  i_exmem_rd,
  input  logic [BUS_WIDTH-1:0] i_exmem_data,
  input  logic                 i_memwb_reg_write,
  input  logic [REG_ADDR-1:0]  i_memwb_rd,
  input  logic [BUS_WIDTH-1:0] i_memwb_data,
  output logic [BUS_WIDTH-1:0] o_alu_a,
  output logic [BUS_WIDTH-1:0] o_alu_b,
  output logic [OP_BITS-1:0]   o_alu_opcode,
  output logic [BUS_WIDTH-1:0] o_store_data,
  output logic [REG_ADDR-1:0]  o_write_reg,
  output logic [REG_ADDR-1:0]  o_rt_ex,
  output logic                 o_reg_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_mem_to_reg
);

  localparam logic [OP_BITS-1:0] ALU_SLL = OP_BITS'(4'b0000);
  localparam logic [OP_BITS-1:0] ALU_SRL = OP_BITS'(4'b0001);
  localparam logic [OP_BITS-1:0] ALU_SRA = OP_BITS'(4'b0010);
  localparam logic [OP_BITS-1:0] ALU_ADD = OP_BITS'(4'b0011);
  localparam logic [OP_BITS-1:0] ALU_AND = OP_BITS'(4'b0100);
  localparam logic [OP_BITS-1:0] ALU_OR  = OP_BITS'(4'b0101);
  localparam logic [OP_BITS-1:0] ALU_XOR = OP_BITS'(4'b0110);
  localparam logic [OP_BITS-1:0] ALU_NOR = OP_BITS'(4'b0111);
  localparam logic [OP_BITS-1:0] ALU_SUB = OP_BITS'(4'b1000);
  localparam logic [OP_BITS-1:0] ALU_SLT = OP_BITS'(4'b1001);

  localparam logic [5:0] OPC_LUI = 6'b001111;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] rs_data;
    logic [BUS_WIDTH-1:0] rt_data;
    logic [BUS_WIDTH-1:0] imm;
    logic [4:0]           shamt;
    logic [5:0]           funct;
    logic [5:0]           opcode;
    logic [REG_ADDR-1:0]  rs;
    logic [REG_ADDR-1:0]  rt;
    logic [REG_ADDR-1:0]  rd;
    logic [1:0]           alu_op;
    logic                 alu_src;
    logic                 reg_dst;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;

  logic [BUS_WIDTH-1:0] fwd_rs;
  logic [BUS_WIDTH-1:0] fwd_rt;
  logic                 is_rtype;
  logic                 shift_imm;
  logic                 shift_var;
  logic                 is_lui;

  // Pack the ID-side fields into one register payload.
  always_comb begin
    d            = '0;
    d.rs_data    = i_rs_data;
    d.rt_data    = i_rt_data;
    d.imm        = i_imm;
    d.shamt      = i_shamt;
    d.funct      = i_funct;
    d.opcode     = i_opcode;
    d.rs         = i_rs;
    d.rt         = i_rt;
    d.rd         = i_rd;
    d.alu_op     = i_alu_op;
    d.alu_src    = i_alu_src;
    d.reg_dst    = i_reg_dst;
    d.reg_write  = i_reg_write;
    d.mem_read   = i_mem_read;
    d.mem_write  = i_mem_write;
    d.mem_to_reg = i_mem_to_reg;
  end

  // Pipeline register: reset > flush (bubble, even while stalled) > stall > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (i_flush) begin
      q <= '0;
    end else if (!i_stall) begin
      q <= d;
    end
  end

  // Forwarding: EX/MEM has priority over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_rs = q.rs_data;
    fwd_rt = q.rt_data;
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == q.rs)) begin
      fwd_rs = i_exmem_data;
    end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == q.rs)) begin
      fwd_rs = i_memwb_data;
    end
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == q.rt)) begin
      fwd_rt = i_exmem_data;
    end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == q.rt)) begin
      fwd_rt = i_memwb_data;
    end
  end

  // Operand selection; shift forms only apply to R-type, LUI only to I-type.
  always_comb begin
    is_rtype  = (q.alu_op == 2'b10);
    shift_imm = is_rtype && ((q.funct == 6'b000000) || (q.funct == 6'b000010) ||
                             (q.funct == 6'b000011));
    shift_var = is_rtype && ((q.funct == 6'b000100) || (q.funct == 6'b000110) ||
                             (q.funct == 6'b000111));
    is_lui    = (q.alu_op == 2'b11) && (q.opcode == OPC_LUI);

    o_alu_a = fwd_rs;
    o_alu_b = q.alu_src ? q.imm : fwd_rt;
    if (shift_imm) begin
      o_alu_a = fwd_rt;
      o_alu_b = BUS_WIDTH'(q.shamt);
    end else if (shift_var) begin
      o_alu_a = fwd_rt;
      o_alu_b = BUS_WIDTH'(fwd_rs[4:0]);
    end else if (is_lui) begin
      o_alu_a = q.imm;
      o_alu_b = BUS_WIDTH'(16);
    end
  end

  // ALU control decode.
  always_comb begin
    o_alu_opcode = ALU_ADD;
    unique case (q.alu_op)
      2'b00: o_alu_opcode = ALU_ADD;
      2'b01: o_alu_opcode = ALU_SUB;
      2'b10: begin
        case (q.funct)
          6'b000000, 6'b000100: o_alu_opcode = ALU_SLL;
          6'b000010, 6'b000110: o_alu_opcode = ALU_SRL;
          6'b000011, 6'b000111: o_alu_opcode = ALU_SRA;
          6'b100000, 6'b100001: o_alu_opcode = ALU_ADD;
          6'b100010, 6'b100011: o_alu_opcode = ALU_SUB;
          6'b100100:            o_alu_opcode = ALU_AND;
          6'b100101:            o_alu_opcode = ALU_OR;
          6'b100110:            o_alu_opcode = ALU_XOR;
          6'b100111:            o_alu_opcode = ALU_NOR;
          6'b101010:            o_alu_opcode = ALU_SLT;
          default:              o_alu_opcode = ALU_ADD;
        endcase
      end
      2'b11: begin
        case (q.opcode)
          6'b001000, 6'b001001: o_alu_opcode = ALU_ADD;
          6'b001010:            o_alu_opcode = ALU_SLT;
          6'b001100:            o_alu_opcode = ALU_AND;
          6'b001101:            o_alu_opcode = ALU_OR;
          6'b001110:            o_alu_opcode = ALU_XOR;
          OPC_LUI:              o_alu_opcode = ALU_SLL;
          default:              o_alu_opcode = ALU_ADD;
        endcase
      end
      default: o_alu_opcode = ALU_ADD;
    endcase
  end

  // Downstream fields.
  always_comb begin
    o_store_data = fwd_rt;
    o_write_reg  = q.reg_dst ? q.rd : q.rt;
    o_rt_ex      = q.rt;
    o_reg_write  = q.reg_write;
    o_mem_read   = q.mem_read;
    o_mem_write  = q.mem_write;
    o_mem_to_reg = q.mem_to_reg;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for id_ex_operand_stage.
// Stimulus changes inputs 1 time unit after the rising edge and queues the
// expected outputs; the monitor pops one entry per falling edge and compares.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stall, i_flush;
  logic [31:0] i_rs_data, i_rt_data, i_imm;
  logic [4:0]  i_shamt;
  logic [5:0]  i_funct, i_opcode;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [1:0]  i_alu_op;
  logic        i_alu_src, i_reg_dst, i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
  logic        i_exmem_reg_write, i_memwb_reg_write;
  logic [4:0]  i_exmem_rd, i_memwb_rd;
  logic [31:0] i_exmem_data, i_memwb_data;
  logic [31:0] o_alu_a, o_alu_b, o_store_data;
  logic [3:0]  o_alu_opcode;
  logic [4:0]  o_write_reg, o_rt_ex;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opc;
    logic [31:0] store;
    logic [4:0]  wreg;
    logic [4:0]  rt;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
  } out_t;

  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  id_ex_operand_stage #(.BUS_WIDTH(32), .OP_BITS(4), .REG_ADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
    .i_shamt(i_shamt), .i_funct(i_funct), .i_opcode(i_opcode),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_alu_op(i_alu_op),
    .i_alu_src(i_alu_src), .i_reg_dst(i_reg_dst), .i_reg_write(i_reg_write),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
    .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd(i_exmem_rd),
    .i_exmem_data(i_exmem_data), .i_memwb_reg_write(i_memwb_reg_write),
    .i_memwb_rd(i_memwb_rd), .i_memwb_data(i_memwb_data),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_opcode(o_alu_opcode),
    .o_store_data(o_store_data), .o_write_reg(o_write_reg), .o_rt_ex(o_rt_ex),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    out_t  act;
    out_t  e;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act = '{o_alu_a, o_alu_b, o_alu_opcode, o_store_data, o_write_reg, o_rt_ex,
              o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h opc=%b st=%h wr=%0d rt=%0d ctl=%b%b%b%b, expected a=%h b=%h opc=%b st=%h wr=%0d rt=%0d ctl=%b%b%b%b",
                 n, act.a, act.b, act.opc, act.store, act.wreg, act.rt,
                 act.rw, act.mr, act.mw, act.mtr,
                 e.a, e.b, e.opc, e.store, e.wreg, e.rt, e.rw, e.mr, e.mw, e.mtr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    i_rs_data = '0; i_rt_data = '0; i_imm = '0; i_shamt = '0;
    i_funct = '0; i_opcode = '0; i_rs = '0; i_rt = '0; i_rd = '0;
    i_alu_op = '0; i_alu_src = 0; i_reg_dst = 0; i_reg_write = 0;
    i_mem_read = 0; i_mem_write = 0; i_mem_to_reg = 0;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    i_exmem_reg_write = ew; i_exmem_rd = erd; i_exmem_data = ed;
    i_memwb_reg_write = mw; i_memwb_rd = mrd; i_memwb_data = md;
  endtask

  task automatic expect_out(input string n, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] opc, input logic [31:0] st,
                            input logic [4:0] wr, input logic [4:0] rt,
                            input logic [3:0] ctl);
    out_t e;
    e = '{a, b, opc, st, wr, rt, ctl[3], ctl[2], ctl[1], ctl[0]};
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // ctl nibble order: reg_write, mem_read, mem_write, mem_to_reg
  task automatic load_sub();
    clear_id();
    i_rs = 5; i_rs_data = 32'd10; i_rt = 6; i_rt_data = 32'd3; i_rd = 7;
    i_funct = 6'b100010; i_alu_op = 2'b10; i_reg_dst = 1; i_reg_write = 1;
  endtask

  initial begin
    rst_n = 0; i_stall = 0; i_flush = 0;
    clear_id();
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    expect_out("reset_state", 0, 0, 4'b0011, 0, 0, 0, 4'b0000);
    tick();
    rst_n = 1;

    // R-type SUB, then forwarding variants on the same registered state
    load_sub();
    tick(); set_fwd(0, 0, 0, 0, 0, 0);
    expect_out("sub_plain", 10, 3, 4'b1000, 3, 7, 6, 4'b1000);
    tick(); set_fwd(1, 5, 32'd7, 1, 5, 32'd9);
    expect_out("sub_exmem_prio", 7, 3, 4'b1000, 3, 7, 6, 4'b1000);
    tick(); set_fwd(1, 0, 32'd7, 1, 5, 32'd9);
    expect_out("sub_memwb_r0", 9, 3, 4'b1000, 3, 7, 6, 4'b1000);
    tick(); set_fwd(0, 6, 32'd1, 1, 6, 32'h55);
    expect_out("sub_fwd_rt", 10, 32'h55, 4'b1000, 32'h55, 7, 6, 4'b1000);

    // SLL shamt=4
    clear_id();
    i_funct = 6'b000000; i_shamt = 4; i_rt = 1; i_rt_data = 1;
    i_rs_data = 32'hDEAD; i_rd = 8; i_alu_op = 2'b10; i_reg_dst = 1; i_reg_write = 1;
    tick(); set_fwd(0, 0, 0, 0, 0, 0);
    expect_out("sll_imm", 1, 4, 4'b0000, 1, 8, 1, 4'b1000);

    // SRAV: B is the low five bits of rs
    clear_id();
    i_funct = 6'b000111; i_rs = 2; i_rs_data = 32'h23; i_rt = 3;
    i_rt_data = 32'h8000_0000; i_rd = 9; i_alu_op = 2'b10; i_reg_dst = 1; i_reg_write = 1;
    tick();
    expect_out("srav", 32'h8000_0000, 3, 4'b0010, 32'h8000_0000, 9, 3, 4'b1000);

    // LUI
    clear_id();
    i_alu_op = 2'b11; i_opcode = 6'b001111; i_imm = 32'h1234; i_alu_src = 1;
    i_rt = 4; i_rt_data = 32'h77; i_reg_write = 1;
    tick();
    expect_out("lui", 32'h1234, 16, 4'b0000, 32'h77, 4, 4, 4'b1000);

    // ADDI with all-ones immediate
    clear_id();
    i_alu_op = 2'b11; i_opcode = 6'b001000; i_imm = 32'hFFFF_FFFF; i_alu_src = 1;
    i_rs = 1; i_rs_data = 5; i_rt = 10; i_rt_data = 32'hAA; i_reg_write = 1;
    tick();
    expect_out("addi", 5, 32'hFFFF_FFFF, 4'b0011, 32'hAA, 10, 10, 4'b1000);

    // SLTI
    i_opcode = 6'b001010;
    tick();
    expect_out("slti", 5, 32'hFFFF_FFFF, 4'b1001, 32'hAA, 10, 10, 4'b1000);

    // Load word
    clear_id();
    i_alu_op = 2'b00; i_alu_src = 1; i_mem_read = 1; i_mem_to_reg = 1; i_reg_write = 1;
    i_rs = 1; i_rs_data = 32'h100; i_imm = 8; i_rt = 11; i_rt_data = 32'h33;
    tick();
    expect_out("lw", 32'h100, 8, 4'b0011, 32'h33, 11, 11, 4'b1101);

    // Store word with forwarded store data
    clear_id();
    i_alu_op = 2'b00; i_alu_src = 1; i_mem_write = 1;
    i_rs = 2; i_rs_data = 32'h200; i_imm = 4; i_rt = 12; i_rt_data = 32'h11;
    tick(); set_fwd(0, 0, 0, 1, 12, 32'h99);
    expect_out("sw_fwd", 32'h200, 4, 4'b0011, 32'h99, 12, 12, 4'b0010);

    // Undefined funct decodes to ADD; register 0 is never forwarded
    clear_id();
    i_funct = 6'b111111; i_alu_op = 2'b10; i_rs = 0; i_rs_data = 1;
    i_rt = 4; i_rt_data = 2; i_rd = 5; i_reg_dst = 1; i_reg_write = 1;
    tick(); set_fwd(1, 0, 32'hBAD, 1, 0, 32'hBAD);
    expect_out("undef_funct_r0", 1, 2, 4'b0011, 2, 5, 4, 4'b1000);

    // AND, then stall two cycles with changing inputs
    clear_id();
    i_funct = 6'b100100; i_alu_op = 2'b10; i_rs = 1; i_rs_data = 32'hF0;
    i_rt = 2; i_rt_data = 32'h3C; i_rd = 3; i_reg_dst = 1; i_reg_write = 1;
    tick(); set_fwd(0, 0, 0, 0, 0, 0);
    expect_out("and", 32'hF0, 32'h3C, 4'b0100, 32'h3C, 3, 2, 4'b1000);
    i_stall = 1;
    i_funct = 6'b100101; i_rs_data = 32'h1; i_rt_data = 32'h2; i_rd = 20; i_mem_write = 1;
    tick(); set_fwd(1, 1, 32'h0F, 0, 0, 0);
    expect_out("stall_fwd", 32'h0F, 32'h3C, 4'b0100, 32'h3C, 3, 2, 4'b1000);
    i_rd = 21;
    tick(); set_fwd(0, 0, 0, 0, 0, 0);
    expect_out("stall_hold", 32'hF0, 32'h3C, 4'b0100, 32'h3C, 3, 2, 4'b1000);
    i_flush = 1;
    tick();
    expect_out("flush_in_stall", 0, 0, 4'b0011, 0, 0, 0, 4'b0000);
    i_stall = 0; i_flush = 0;

    // Reset asserted between edges with live state
    load_sub();
    tick();
    expect_out("pre_reset", 10, 3, 4'b1000, 3, 7, 6, 4'b1000);
    tick();
    #1 rst_n = 0;
    expect_out("async_reset", 0, 0, 4'b0011, 0, 0, 0, 4'b0000);
    tick();
    rst_n = 1;

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations still queued, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
